// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor (D = A - B, LSB first) with valid/ready handshakes.
// Optional signed-overflow flag enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] d,
  output logic         bout,
  output logic         ovf
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   sa_q, sa_d;
  logic [N-1:0]   sb_q, sb_d;
  logic [N-1:0]   sd_q, sd_d;
  logic           br_q, br_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           x, y, diffBit;
  logic           lastBit;

  assign x       = sa_q[0];
  assign y       = sb_q[0];
  assign diffBit = x ^ y ^ br_q;
  assign lastBit = (state_q == RUN) && (cnt_q == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      sd_q    <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      sd_q    <= sd_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    sd_d    = sd_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = RUN;
          sa_d    = a;
          sb_d    = b;
          sd_d    = '0;
          br_d    = 1'b0;
          cnt_d   = '0;
        end
      end
      RUN: begin
        sa_d = sa_q >> 1;
        sb_d = sb_q >> 1;
        sd_d = {diffBit, sd_q[N-1:1]};
        br_d = (~x & y) | (~(x ^ y) & br_q);
        // Counter saturates at the last bit so it never exceeds N-1.
        if (cnt_q == LAST) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign d         = sd_q;
  assign bout      = br_q;

`ifdef SERIAL_SUB_OVF_EN
  logic bmsb_q, bmsb_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bmsb_q <= 1'b0;
    end else begin
      bmsb_q <= bmsb_d;
    end
  end

  // Borrow into the MSB is the borrow present just before the final bit.
  always_comb begin
    bmsb_d = bmsb_q;
    if (in_ready && in_valid) begin
      bmsb_d = 1'b0;
    end else if (lastBit) begin
      bmsb_d = br_q;
    end
  end

  assign ovf = bmsb_q ^ br_q;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and back-to-back checks for serial_subtractor at N=8.
// Overflow expectations follow SERIAL_SUB_OVF_EN.
module tb_serial_subtractor;

  localparam int N = 8;
`ifdef SERIAL_SUB_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a, b;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] d;
  logic         bout;
  logic         ovf;

  int      checks = 0;
  int      passes = 0;
  longint  cyc = 0;

  serial_subtractor #(.N(N)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .d(d), .bout(bout), .ovf(ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] av;
    logic [7:0] bv;
    logic [7:0] expD;
    logic       expB;
    logic       expOvfSigned;
  } vec_t;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Starts one operation from IDLE (at posedge+1) and waits for out_valid.
  task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv, input bit holdValid,
                               output longint hsCyc);
    int lat;
    checkOutput("in_ready before op", in_ready, 1);
    a = av; b = bv; in_valid = 1'b1;
    @(posedge clk); #1;
    hsCyc = cyc;
    if (!holdValid) in_valid = 1'b0;
    a = ~av; b = 8'($urandom);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput("latency", lat, 8);
  endtask

  function automatic logic modelOvf(input logic [7:0] av, input logic [7:0] bv);
    logic [7:0] dd;
    dd = av - bv;
    return OVF_EN && (av[7] != bv[7]) && (dd[7] != av[7]);
  endfunction

  vec_t   vecs[8];
  longint hs, prevHs;
  int     seen;
  logic [7:0] ra, rb, holdD;
  logic       holdB, holdO;

  initial begin
    vecs[0] = '{8'h05, 8'h03, 8'h02, 1'b0, 1'b0};
    vecs[1] = '{8'h03, 8'h05, 8'hFE, 1'b1, 1'b0};
    vecs[2] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
    vecs[3] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1};
    vecs[4] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
    vecs[5] = '{8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0};
    vecs[6] = '{8'h00, 8'hFF, 8'h01, 1'b1, 1'b0};
    vecs[7] = '{8'h7F, 8'h80, 8'hFF, 1'b1, 1'b1};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    checkOutput("reset in_ready", in_ready, 1);
    checkOutput("reset out_valid", out_valid, 0);
    checkOutput("reset d", d, 0);
    checkOutput("reset bout", bout, 0);
    checkOutput("reset ovf", ovf, 0);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].av, vecs[i].bv, 1'b0, hs);
      checkOutput($sformatf("vec%0d d", i), d, vecs[i].expD);
      checkOutput($sformatf("vec%0d bout", i), bout, vecs[i].expB);
      checkOutput($sformatf("vec%0d ovf", i), ovf, vecs[i].expOvfSigned & OVF_EN);
      @(posedge clk); #1;
      checkOutput($sformatf("vec%0d release", i), {out_valid, in_ready}, 2'b01);
    end

    // Backpressure: result must hold and new operands must be ignored.
    out_ready = 1'b0;
    applyStimulus(8'h5A, 8'h3C, 1'b0, hs);
    holdD = d; holdB = bout; holdO = ovf;
    checkOutput("bp d", holdD, 8'h1E);
    checkOutput("bp bout", holdB, 0);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0]; a = 8'hC3; b = 8'h11;
      @(posedge clk); #1;
      checkOutput("bp hold", {out_valid, in_ready, d, bout, ovf}, {1'b1, 1'b0, 8'h1E, 1'b0, 1'b0});
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("bp release", {out_valid, in_ready}, 2'b01);

    // Reset in the middle of a run discards the partial result.
    a = 8'hAA; b = 8'h55; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    #2;
    checkOutput("midrst outputs", {out_valid, in_ready, d, bout, ovf}, {1'b0, 1'b1, 8'h00, 1'b0, 1'b0});
    @(posedge clk); #1 reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    checkOutput("midrst no out_valid", seen, 0);
    applyStimulus(8'h10, 8'h01, 1'b0, hs);
    checkOutput("after rst d", {d, bout, ovf}, {8'h0F, 1'b0, 1'b0});
    @(posedge clk); #1;

    // Back-to-back with in_valid held high.
    prevHs = 0;
    for (int i = 0; i < 100; i++) begin
      ra = 8'($urandom); rb = 8'($urandom);
      applyStimulus(ra, rb, 1'b1, hs);
      checkOutput($sformatf("b2b%0d result", i), {d, bout, ovf},
                  {8'(ra - rb), (ra < rb), modelOvf(ra, rb)});
      if (i > 0) checkOutput($sformatf("b2b%0d interval", i), hs - prevHs, 10);
      prevHs = hs;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
